field_nbr_fetch: RTL and testbench
==================================

// Module: field_nbr_fetch
// PURPOSE
// - Double-buffered Game-of-Life field store; responder side of next_field_iter.
// - Serves cell state + 8 neighbours for the iterator's requested (next_x, next_y).
//   Accepts the iterator's new-state write-back into the write field.
// - Provides a display read port and a host load/clear path.
// - Sits between next_field_iter and the video/UI logic.
// PARAMETERS
// - FIELD_W     5   field width in cells
// - FIELD_H     3   field height in cells
// - X_ADR_SIZE  $clog2(FIELD_W)  x address width (derived)
// - Y_ADR_SIZE  $clog2(FIELD_H)  y address width (derived)
// PORTS
// - clk                   in   1   single clock, all logic on posedge
// - rst                   in   1   asynchronous, active-high reset
// - i_cur_read_field      in   cur_field_t   field being read; write field = ~this
// - i_is_simulating       in   1   iterator busy; enables write-back
// - i_next_x / i_next_y   in   X/Y_ADR_SIZE  fetch address
// - i_cur_x / i_cur_y     in   X/Y_ADR_SIZE  write-back address
// - i_new_cur_cell_state  in   1   write-back data
// - o_next_cell_state     out  1   registered cell state at fetch address
// - o_next_nbrs           out  8   registered neighbour states
// - i_disp_x / i_disp_y   in   X/Y_ADR_SIZE  display read address
// - o_disp_cell           out  1   registered read-field cell at display address
// - i_load_we             in   1   host write strobe
// - i_load_x / i_load_y   in   X/Y_ADR_SIZE  host write address
// - i_load_val            in   1   host write data
// - i_clear               in   1   pulse: start zeroing both fields
// - o_busy                out  1   high while clearing
// BEHAVIOUR
// Reset
// - rst: all outputs 0, FSM=IDLE, clear row counter 0.
// - Storage arrays are NOT reset.
// Fetch
// - Each posedge, outputs are registered from the read field at (i_next_x, i_next_y).
// - Latency 1: address driven in cycle N appears on outputs in cycle N+1, aligned with the iterator's cur_x/cur_y.
// - nbrs bit order:
//   - 0=(x-1,y-1), 1=(x,y-1), 2=(x+1,y-1), 3=(x-1,y),
//   - 4=(x+1,y), 5=(x-1,y+1), 6=(x,y+1), 7=(x+1,y+1).
// Write-back
// - If i_is_simulating && FSM==IDLE: at posedge, write field[(i_cur_x, i_cur_y)] <= i_new_cur_cell_state.
// - The write-back target is never the read field, so there is no fetch collision.
// Load
// - If i_load_we && !i_is_simulating && FSM==IDLE: read field[(i_load_x, i_load_y)] <= i_load_val.
// - Ignored otherwise.
// - Same-cycle fetch or display of that cell returns the old value (read-before-write).
// Display
// - o_disp_cell is registered, latency 1.
// - It is always from the current read field.
// Clear FSM
// - IDLE -> CLEAR when i_clear && !i_is_simulating; the pulse is otherwise dropped.
// - CLEAR zeroes row r of both fields each cycle, r = 0..FIELD_H-1. o_busy is 1.
// - After row FIELD_H-1, return to IDLE. Clear lasts exactly FIELD_H cycles.
// - i_clear during CLEAR is ignored; the sweep does not restart.
// - Load and write-back are suppressed during CLEAR.
// - Fetch and display outputs stay live and may show partly cleared data.
// - rst mid-CLEAR aborts to IDLE. Unswept rows keep their contents.
// Address bounds
// - Addresses >= FIELD_W/FIELD_H: reads return 0, writes are dropped.
// CONFIGURATION
// - TORUS_WRAP_EN defined: neighbour coordinates wrap.
//   - x-1 at x=0 -> FIELD_W-1; x+1 at FIELD_W-1 -> 0; same for y.
// - TORUS_WRAP_EN undefined: neighbours outside the field read as 0 (dead border).
// TESTING
// 1. Load single live cell (2,1) into FIELD_A, read=FIELD_A; fetch (1,0) -> next cycle nbrs=8'b1000_0000, state=0.
// 2. Same cell, fetch (2,1) -> state=1, nbrs=0.
//    Fetch (3,1) -> nbrs bit3=1 only.
// 3. Live cell (4,2), fetch (0,0):
//    - TORUS_WRAP_EN defined -> nbrs bit0=1.
//    - Undefined -> nbrs=0.
// 4. Full iterator pass with random states: every written cell appears in FIELD_B.
//    After the toggle to read=FIELD_B, fetch matches; FIELD_A unchanged.
// 5. Fill field with 1s, pulse i_clear:
//    - o_busy high exactly 3 cycles, then all fetches return 0.
//    - i_load_we during busy is ignored.
// 6. Assert rst during cycle 2 of clear:
//    - Outputs 0 and o_busy=0 immediately.
//    - Row 2 still holds 1s after rst.

Source files
------------

// File: rtl/field_nbr_fetch_if.sv
// field_nbr_fetch_if: iterator fetch/write-back, display and host load/clear signals.
// master = iterator/host/display side, slave = the field store.
typedef enum logic {FIELD_A = 1'b0, FIELD_B = 1'b1} cur_field_t;

interface field_nbr_fetch_if #(
    parameter int FIELD_W    = 5,
    parameter int FIELD_H    = 3,
    parameter int X_ADR_SIZE = $clog2(FIELD_W),
    parameter int Y_ADR_SIZE = $clog2(FIELD_H)
);
    cur_field_t            i_cur_read_field;
    logic                  i_is_simulating;
    logic [X_ADR_SIZE-1:0] i_next_x, i_cur_x, i_disp_x, i_load_x;
    logic [Y_ADR_SIZE-1:0] i_next_y, i_cur_y, i_disp_y, i_load_y;
    logic                  i_new_cur_cell_state;
    logic                  o_next_cell_state;
    logic [7:0]            o_next_nbrs;
    logic                  o_disp_cell;
    logic                  i_load_we, i_load_val;
    logic                  i_clear, o_busy;

    modport master (
        output i_cur_read_field, i_is_simulating, i_next_x, i_next_y, i_cur_x, i_cur_y,
               i_new_cur_cell_state, i_disp_x, i_disp_y, i_load_we, i_load_x, i_load_y,
               i_load_val, i_clear,
        input  o_next_cell_state, o_next_nbrs, o_disp_cell, o_busy
    );

    modport slave (
        input  i_cur_read_field, i_is_simulating, i_next_x, i_next_y, i_cur_x, i_cur_y,
               i_new_cur_cell_state, i_disp_x, i_disp_y, i_load_we, i_load_x, i_load_y,
               i_load_val, i_clear,
        output o_next_cell_state, o_next_nbrs, o_disp_cell, o_busy
    );
endinterface

// File: rtl/field_nbr_fetch.sv
// field_nbr_fetch: double-buffered Game-of-Life field; serves cell + 8 neighbours, write-back, display, host load/clear.
// TORUS_WRAP_EN: when defined, neighbour coordinates wrap around the field edges (otherwise dead border).
module field_nbr_fetch #(
    parameter int FIELD_W = 5,
    parameter int FIELD_H = 3
) (
    input logic clk,
    input logic rst,
    field_nbr_fetch_if.slave bus
);
    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);
    localparam logic [Y_ADR_SIZE-1:0] LAST_ROW = Y_ADR_SIZE'(FIELD_H - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [Y_ADR_SIZE-1:0] row;
    logic [FIELD_W-1:0]    mem [2][FIELD_H];
    logic                  rf, fetch_ok, disp_ok, wb_ok, load_ok;
    logic                  cell_nxt, disp_nxt;
    logic [7:0]            nbrs_nxt;
    int                    nx, ny;

    function automatic logic in_field(input int x, input int y);
        return x >= 0 && x < FIELD_W && y >= 0 && y < FIELD_H;
    endfunction

    // only the -1 / W steps of a neighbour offset can leave the field, so wrapping those is enough
    function automatic logic rd(input logic f, input int x, input int y);
        int xx, yy;
`ifdef TORUS_WRAP_EN
        xx = x < 0 ? FIELD_W - 1 : x >= FIELD_W ? 0 : x;
        yy = y < 0 ? FIELD_H - 1 : y >= FIELD_H ? 0 : y;
`else
        xx = x;
        yy = y;
`endif
        return in_field(xx, yy) ? mem[f][yy[Y_ADR_SIZE-1:0]][xx[X_ADR_SIZE-1:0]] : 1'b0;
    endfunction

    always_comb begin
        rf       = bus.i_cur_read_field;
        nx       = int'(bus.i_next_x);
        ny       = int'(bus.i_next_y);
        fetch_ok = in_field(nx, ny);
        disp_ok  = in_field(int'(bus.i_disp_x), int'(bus.i_disp_y));
        wb_ok    = in_field(int'(bus.i_cur_x), int'(bus.i_cur_y));
        load_ok  = in_field(int'(bus.i_load_x), int'(bus.i_load_y));
        cell_nxt = fetch_ok & rd(rf, nx, ny);
        disp_nxt = disp_ok & rd(rf, int'(bus.i_disp_x), int'(bus.i_disp_y));
        nbrs_nxt = {8{fetch_ok}} & {rd(rf, nx + 1, ny + 1), rd(rf, nx, ny + 1), rd(rf, nx - 1, ny + 1),
                                    rd(rf, nx + 1, ny),                         rd(rf, nx - 1, ny),
                                    rd(rf, nx + 1, ny - 1), rd(rf, nx, ny - 1), rd(rf, nx - 1, ny - 1)};
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[0][row] <= '0;
            mem[1][row] <= '0;
        end else begin
            if (bus.i_is_simulating && wb_ok)
                mem[~rf][bus.i_cur_y][bus.i_cur_x] <= bus.i_new_cur_cell_state;
            if (bus.i_load_we && !bus.i_is_simulating && load_ok)
                mem[rf][bus.i_load_y][bus.i_load_x] <= bus.i_load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= state_nxt;
            row   <= state == CLEAR && row != LAST_ROW ? row + 1'b1 : '0;
        end
    end

    always_comb
        state_nxt = state == IDLE ? (bus.i_clear && !bus.i_is_simulating ? CLEAR : IDLE)
                                  : (row == LAST_ROW ? IDLE : CLEAR);

    always_comb bus.o_busy = state == CLEAR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_next_cell_state <= 1'b0;
            bus.o_next_nbrs       <= '0;
            bus.o_disp_cell       <= 1'b0;
        end else begin
            bus.o_next_cell_state <= cell_nxt;
            bus.o_next_nbrs       <= nbrs_nxt;
            bus.o_disp_cell       <= disp_nxt;
        end
    end
endmodule

// File: tb/tb_field_nbr_fetch.sv
// tb_field_nbr_fetch: directed checks of fetch, neighbours, write-back, load, display, clear and reset abort.
module tb_field_nbr_fetch;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int passed = 0;
    logic [14:0] pat = 15'b110_0101_1010_0111;

    field_nbr_fetch_if #(.FIELD_W(5), .FIELD_H(3)) bus ();
    field_nbr_fetch #(.FIELD_W(5), .FIELD_H(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int x, input int y, input logic v);
        bus.i_load_x   = 3'(x);
        bus.i_load_y   = 2'(y);
        bus.i_load_val = v;
        bus.i_load_we  = 1'b1;
        tick;
        bus.i_load_we  = 1'b0;
    endtask

    task automatic fetch(input int x, input int y);
        bus.i_next_x = 3'(x);
        bus.i_next_y = 2'(y);
        tick;
    endtask

    task automatic disp(input int x, input int y);
        bus.i_disp_x = 3'(x);
        bus.i_disp_y = 2'(y);
        tick;
    endtask

    task automatic fill_a;
        bus.i_cur_read_field = FIELD_A;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) load(x, y, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_cur_read_field = FIELD_A;
        bus.i_is_simulating = 1'b0;
        bus.i_next_x = '0; bus.i_next_y = '0;
        bus.i_cur_x = '0; bus.i_cur_y = '0;
        bus.i_new_cur_cell_state = 1'b0;
        bus.i_disp_x = '0; bus.i_disp_y = '0;
        bus.i_load_we = 1'b0; bus.i_load_x = '0; bus.i_load_y = '0; bus.i_load_val = 1'b0;
        bus.i_clear = 1'b0;
        repeat (2) tick;
        check("rst_state", bus.o_next_cell_state, 0);
        check("rst_nbrs", bus.o_next_nbrs, 0);
        check("rst_disp", bus.o_disp_cell, 0);
        check("rst_busy", bus.o_busy, 0);
        rst = 1'b0;
        bus.i_clear = 1'b1;
        tick;
        bus.i_clear = 1'b0;
        check("clr0_busy1", bus.o_busy, 1);
        tick; check("clr0_busy2", bus.o_busy, 1);
        tick; check("clr0_busy3", bus.o_busy, 1);
        tick; check("clr0_done", bus.o_busy, 0);

        load(2, 1, 1'b1);
        fetch(1, 0);
        check("f10_nbrs", bus.o_next_nbrs, 8'b1000_0000);
        check("f10_state", bus.o_next_cell_state, 0);
        fetch(2, 1);
        check("f21_state", bus.o_next_cell_state, 1);
        check("f21_nbrs", bus.o_next_nbrs, 8'h00);
        fetch(3, 1);
        check("f31_nbrs", bus.o_next_nbrs, 8'b0000_1000);
        disp(2, 1);
        check("d21", bus.o_disp_cell, 1);

        bus.i_next_x = 3'd0; bus.i_next_y = 2'd2;
        bus.i_disp_x = 3'd0; bus.i_disp_y = 2'd2;
        bus.i_load_x = 3'd0; bus.i_load_y = 2'd2; bus.i_load_val = 1'b1; bus.i_load_we = 1'b1;
        tick;
        bus.i_load_we = 1'b0;
        check("rbw_state_old", bus.o_next_cell_state, 0);
        check("rbw_disp_old", bus.o_disp_cell, 0);
        tick;
        check("rbw_state_new", bus.o_next_cell_state, 1);
        check("rbw_disp_new", bus.o_disp_cell, 1);
        load(0, 2, 1'b0);

        load(4, 2, 1'b1);
        fetch(0, 0);
`ifdef TORUS_WRAP_EN
        check("wrap00_nbrs", bus.o_next_nbrs, 8'b0000_0001);
`else
        check("wrap00_nbrs", bus.o_next_nbrs, 8'b0000_0000);
`endif
        check("wrap00_state", bus.o_next_cell_state, 0);
        fetch(7, 3);
        check("oor_state", bus.o_next_cell_state, 0);
        check("oor_nbrs", bus.o_next_nbrs, 0);
        disp(5, 2);
        check("oor_disp", bus.o_disp_cell, 0);

        bus.i_is_simulating = 1'b1;
        bus.i_load_x = 3'd0; bus.i_load_y = 2'd1; bus.i_load_val = 1'b1; bus.i_load_we = 1'b1;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) begin
                bus.i_cur_x = 3'(x);
                bus.i_cur_y = 2'(y);
                bus.i_new_cur_cell_state = pat[y*5+x];
                tick;
            end
        bus.i_is_simulating = 1'b0;
        bus.i_load_we = 1'b0;
        bus.i_cur_read_field = FIELD_B;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) begin
                fetch(x, y);
                check($sformatf("wb_b_%0d_%0d", x, y), bus.o_next_cell_state, pat[y*5+x]);
            end
        bus.i_cur_read_field = FIELD_A;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) begin
                disp(x, y);
                check($sformatf("keep_a_%0d_%0d", x, y), bus.o_disp_cell,
                      (x == 2 && y == 1) || (x == 4 && y == 2));
            end

        fill_a;
        bus.i_clear = 1'b1;
        tick;
        bus.i_clear = 1'b0;
        check("clr_busy1", bus.o_busy, 1);
        tick;
        check("clr_busy2", bus.o_busy, 1);
        bus.i_load_x = 3'd0; bus.i_load_y = 2'd0; bus.i_load_val = 1'b1; bus.i_load_we = 1'b1;
        bus.i_clear = 1'b1;
        tick;
        bus.i_load_we = 1'b0;
        bus.i_clear = 1'b0;
        check("clr_busy3", bus.o_busy, 1);
        tick;
        check("clr_done", bus.o_busy, 0);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) begin
                fetch(x, y);
                check($sformatf("clr_a_%0d_%0d", x, y), bus.o_next_cell_state, 0);
            end
        fetch(2, 1);
        check("clr_a_nbrs", bus.o_next_nbrs, 0);
        bus.i_cur_read_field = FIELD_B;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 5; x++) begin
                disp(x, y);
                check($sformatf("clr_b_%0d_%0d", x, y), bus.o_disp_cell, 0);
            end

        fill_a;
        bus.i_next_x = 3'd1; bus.i_next_y = 2'd1;
        bus.i_disp_x = 3'd4; bus.i_disp_y = 2'd2;
        tick;
        check("pre_rst_state", bus.o_next_cell_state, 1);
        bus.i_clear = 1'b1;
        tick;
        bus.i_clear = 1'b0;
        tick;
        #2 rst = 1'b1;
        #1;
        check("abort_state", bus.o_next_cell_state, 0);
        check("abort_nbrs", bus.o_next_nbrs, 0);
        check("abort_disp", bus.o_disp_cell, 0);
        check("abort_busy", bus.o_busy, 0);
        rst = 1'b0;
        tick;
        check("abort_idle", bus.o_busy, 0);
        disp(0, 0);
        check("abort_row0", bus.o_disp_cell, 0);
        disp(3, 1);
        check("abort_row1", bus.o_disp_cell, 1);
        for (int x = 0; x < 5; x++) begin
            disp(x, 2);
            check($sformatf("abort_row2_%0d", x), bus.o_disp_cell, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
